uart_tx: RTL and testbench

//   Serial transmit end of the SoC UART; pairs with the existing receiver (urx) behind the same MMIO UART.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encodings and line level shared by the UART tx/rx pair.
// The PARITY encoding exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int   UART_TX_ST_W = 3;
  localparam logic LINE_IDLE    = 1'b1;

  typedef enum logic [UART_TX_ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter with restart.
// tick is high for one cycle out of every DIV.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, LSB first, idle-high, fed by a byte FIFO.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd via PARITY_ODD).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = 3;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_db_chk
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_sb_chk
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 2) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fd_chk
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_po_chk
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 nempty;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign tx_ready = (count_q != CNT_FULL);
  assign push     = tx_valid & tx_ready;
  assign nempty   = (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(pop),
    .tick   (tick)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        txd_d = LINE_IDLE;
        pop   = nempty;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick && (bit_q == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
          txd_d   = par_q;
`else
          state_d = ST_STOP;
          txd_d   = LINE_IDLE;
          bit_d   = '0;
`endif
        end else if (tick) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = LINE_IDLE;
          bit_d   = '0;
        end
      end
`endif
      ST_STOP: begin
        if (tick && (bit_q == STOP_LAST)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          txd_d   = LINE_IDLE;
          pop     = nempty;
        end else if (tick) begin
          bit_d = bit_q + BIT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
    // Loading the head is shared by IDLE and the back-to-back STOP exit.
    if (pop) begin
      state_d = ST_START;
      shift_d = head;
      txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ PARITY_ODD[0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      txd_q    <= LINE_IDLE;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign txd     = txd_q;
  assign tx_done = done_q;
  assign tx_busy = (state_q != ST_IDLE) | nempty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus against a frame-level reference.
// Two instances: 8N1 (even parity when enabled) and 7-data/2-stop (odd parity).
module tb_uart_tx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 5_000_000;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR    = 1;
`else
  localparam int PAR    = 0;
`endif
  localparam int F1     = DIV * (1 + 8 + 1 + PAR);
  localparam int F2     = DIV * (1 + 7 + 2 + PAR);
  localparam int P_ODD2 = 1;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] tx_data   = '0;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;
  logic [6:0] tx_data2  = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2;
  logic       txd2;
  logic       tx_busy2;
  logic       tx_done2;

  uart_tx #(
    .CLK_FREQ  (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .FIFO_DEPTH(4),
    .PARITY_ODD(0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  uart_tx #(
    .CLK_FREQ  (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (7),
    .STOP_BITS (2),
    .FIFO_DEPTH(4),
    .PARITY_ODD(P_ODD2)
  ) dut2 (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data2),
    .tx_valid(tx_valid2),
    .tx_ready(tx_ready2),
    .txd     (txd2),
    .tx_busy (tx_busy2),
    .tx_done (tx_done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         start_log[$];
  int         done_log[$];
  int         acc_log[$];
  logic       ready_trace[$];
  logic [7:0] seq [16];
  bit         mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line image of one frame: start, data LSB first, parity, then stop ones.
  function automatic logic [15:0] ref_bits(input logic [7:0] b,
                                           input int nd, input int podd);
    logic [15:0] v;
    int idx;
    int ones;
    v    = '1;
    v[0] = 1'b0;
    idx  = 1;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      v[idx] = b[i];
      ones += int'(b[i]);
      idx++;
    end
    if (PAR == 1) v[idx] = ((ones + podd) % 2) != 0;
    return v;
  endfunction

  always @(negedge clk) if (tx_done === 1'b1) done_log.push_back(cyc);

  always begin : mon
    logic [7:0]  b;
    logic [15:0] bits;
    @(negedge clk);
    while (mon_en && txd === 1'b0) begin
      start_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        b = '0;
      end else begin
        b = exp_q.pop_front();
      end
      bits = ref_bits(b, 8, 0);
      for (int k = 0; k < F1; k++) begin
        if (k % DIV == DIV / 2)
          chk($sformatf("bit%0d_of_%02h", k / DIV, b), txd, bits[k / DIV]);
        @(negedge clk);
        if (!mon_en) break;
      end
      if (mon_en) chk("done_pulse", tx_done, 1);
    end
  end

  task automatic send_seq(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 3000) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = seq[i];
      ready_trace.push_back(tx_ready);
      if (tx_ready === 1'b1) begin
        acc_log.push_back(cyc + 1);
        exp_q.push_back(seq[i]);
        i++;
      end
      guard++;
    end
    if (i < n) chk("send_timeout", i, n);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((tx_busy !== 1'b0 || exp_q.size() != 0) && g < 5000);
    chk("idle_reached", g < 5000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic d2_frame(input logic [6:0] b);
    int g = 0;
    int st;
    int acc;
    logic [15:0] bits;
    @(negedge clk);
    chk("d2_ready", tx_ready2, 1);
    tx_data2  = b;
    tx_valid2 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    while (txd2 !== 1'b0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    st = cyc;
    chk("d2_latency", st - acc, 1);
    bits = ref_bits({1'b0, b}, 7, P_ODD2);
    for (int k = 0; k < F2; k++) begin
      if (k % DIV == DIV / 2)
        chk($sformatf("d2_bit%0d_of_%02h", k / DIV, b), txd2, bits[k / DIV]);
      if (k == F2 - 1) chk("d2_done_early", tx_done2, 0);
      @(negedge clk);
    end
    chk("d2_done", tx_done2, 1);
    @(negedge clk);
    chk("d2_done_width", tx_done2, 0);
    chk("d2_busy", tx_busy2, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, a0, r0, st, g, gap;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    mon_en = 1'b1;

    s0 = start_log.size(); d0 = done_log.size(); a0 = acc_log.size();
    seq[0] = 8'h55;
    send_seq(1);
    wait_idle();
    chk("t1_latency", start_log[s0] - acc_log[a0], 1);
    chk("t1_done_at", done_log[d0] - start_log[s0], F1);
    chk("t1_busy_after", tx_busy, 0);

    s0 = start_log.size(); d0 = done_log.size(); a0 = acc_log.size();
    seq[0] = 8'hA5; seq[1] = 8'h3C;
    send_seq(2);
    wait_idle();
    chk("t2_acc_gap", acc_log[a0 + 1] - acc_log[a0], 1);
    chk("t2_start_gap", start_log[s0 + 1] - start_log[s0], F1);
    chk("t2_done_gap", done_log[d0 + 1] - done_log[d0], F1);

    s0 = start_log.size(); d0 = done_log.size();
    a0 = acc_log.size(); r0 = ready_trace.size();
    for (int i = 0; i < 6; i++) seq[i] = 8'($urandom);
    send_seq(6);
    wait_idle();
    chk("t3_ready_after5", ready_trace[r0 + 5], 0);
    chk("t3_acc5_run", acc_log[a0 + 4] - acc_log[a0], 4);
    chk("t3_acc6", acc_log[a0 + 5] - done_log[d0], 1);
    chk("t3_frames", done_log.size() - d0, 6);
    chk("t3_span", start_log[s0 + 5] - start_log[s0], 5 * F1);

    s0 = start_log.size(); d0 = done_log.size();
    seq[0] = 8'h07;
    send_seq(1);
    wait_idle();
    chk("t4_len", done_log[d0] - start_log[s0], F1);

    s0 = start_log.size(); d0 = done_log.size();
    seq[0] = 8'hA5;
    send_seq(1);
    g = 0;
    while (start_log.size() == s0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("t5_started", start_log.size() - s0, 1);
    st = start_log[s0];
    while (cyc < st + 4 * DIV + 3) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("t5_txd", txd, 1);
    chk("t5_ready", tx_ready, 1);
    chk("t5_busy", tx_busy, 0);
    chk("t5_done", tx_done, 0);
    reset = 1'b0;
    repeat (F1 + 20) @(negedge clk);
    chk("t5_no_done", done_log.size() - d0, 0);
    chk("t5_line_idle", txd, 1);
    exp_q.delete();
    mon_en = 1'b1;
    s0 = start_log.size(); d0 = done_log.size();
    seq[0] = 8'h3C;
    send_seq(1);
    wait_idle();
    chk("t5_clean_len", done_log[d0] - start_log[s0], F1);

    d2_frame(7'h7F);
    d2_frame(7'h07);
    d2_frame(7'($urandom));

    d0 = done_log.size();
    for (int i = 0; i < 8; i++) seq[i] = 8'($urandom);
    send_seq(8);
    for (int n = 0; n < 16; n++) begin
      seq[0] = 8'($urandom);
      send_seq(1);
      gap = $urandom_range(0, 3);
      if (gap == 3) gap = $urandom_range(40, 150);
      repeat (gap) @(negedge clk);
    end
    wait_idle();
    chk("t7_frames", done_log.size() - d0, 24);
    chk("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
